// File: rtl/sum_reduce_sequencer.sv
// sum_reduce_sequencer
// Fetches LENGTH consecutive 256-bit words from data memory and presents each
// one on sum_bus to the combinational lane-sum datapath. It accumulates the
// returned 16-bit per-word sums and pulses done once the last word is added.
//
// Ports
//   clk, rst          system clock, synchronous active-high reset
//   start, abort      command strobe (IDLE only) / cancel of a running job
//   base_addr, length first word address and word count, latched on start
//   mem_rd_en/addr    one-cycle read request per word
//   mem_rd_data/valid read return; only accepted while waiting for it
//   sum_bus, sum_in   registered word to the datapath / its 16-bit sum
//   result            accumulated sum, stable from done until the next start
//   busy, done        not-idle flag / one-cycle completion pulse
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; result holds the last completed sum
// S_REQ  | issue read for word base+idx
// S_WAIT | wait (unbounded) for read data, capture it onto sum_bus
// S_ACC  | add datapath sum into acc, advance idx
// S_DONE | one-cycle done pulse, then back to IDLE
module sum_reduce_sequencer #(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [255:0]      mem_rd_data,
  input  logic              mem_rd_valid,
  output logic [255:0]      sum_bus,
  input  logic [15:0]       sum_in,
  output logic [15:0]       result,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_ACC,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic [15:0]       acc;
  logic [15:0]       acc_sum;
  logic              last_word;
  logic              abort_hit;

  assign last_word = (idx == len_q - LEN_W'(1));
  assign abort_hit = abort && (state != S_IDLE);
  // Carry out of the 16-bit add is dropped, matching the datapath's own wrap.
  assign acc_sum   = acc + sum_in;

  always_comb begin
    state_nxt = state;
    mem_rd_en = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mem_addr  = base_q + ADDR_W'(idx);
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (length == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        mem_rd_en = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rd_valid) state_nxt = S_ACC;
      end
      S_ACC: begin
        state_nxt = last_word ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort_hit) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx     <= '0;
      acc     <= '0;
      sum_bus <= '0;
      result  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            len_q  <= length;
            acc    <= '0;
            idx    <= '0;
            if (length == '0) result <= '0;
          end
        end
        S_WAIT: begin
          if (mem_rd_valid && !abort) sum_bus <= mem_rd_data;
        end
        S_ACC: begin
          if (!abort) begin
            acc <= acc_sum;
            idx <= idx + LEN_W'(1);
            // Load result on the way into DONE so it is already valid while
            // done is high.
            if (last_word) result <= acc_sum;
          end
        end
        default: ;
      endcase
      if (abort_hit) begin
        acc <= '0;
        idx <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sum_reduce_sequencer.sv
module tb_sum_reduce_sequencer;

  logic         clk;
  logic         rst;
  logic         start;
  logic         abort;
  logic [15:0]  base_addr;
  logic [7:0]   length;
  logic         mem_rd_en;
  logic [15:0]  mem_addr;
  logic [255:0] mem_rd_data;
  logic         mem_rd_valid;
  logic [255:0] sum_bus;
  logic [15:0]  sum_in;
  logic [15:0]  result;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;

  logic [15:0]  exp_addr[$];
  logic [15:0]  exp_res[$];
  int           lat_q[$];
  logic [255:0] mem [int];

  int           pend_cnt = 0;
  logic [15:0]  pend_addr = '0;
  bit           real_last = 0;
  bit           was_real = 0;
  bit           stray_en = 0;
  bit           chk_res_next = 0;
  logic [15:0]  res_hold = '0;

  sum_reduce_sequencer #(.ADDR_W(16), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid),
    .sum_bus(sum_bus), .sum_in(sum_in), .result(result),
    .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Lane-sum datapath model
  always_comb begin
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + sum_bus[i*16 +: 16];
    sum_in = s;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rep(input logic [15:0] v);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = v;
    return w;
  endfunction

  // Memory model: latency per request from lat_q (default 1); optional stray
  // valid pulses in REQ and in the cycle after a real return (ACC).
  always @(negedge clk) begin
    int k;
    was_real     = real_last;
    real_last    = 0;
    mem_rd_valid = 0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        k = int'(pend_addr);
        mem_rd_data  = mem.exists(k) ? mem[k] : '0;
        mem_rd_valid = 1;
        real_last    = 1;
      end
    end
    if (mem_rd_en) begin
      pend_addr = mem_addr;
      pend_cnt  = (lat_q.size() > 0) ? lat_q.pop_front() : 1;
      if (stray_en && !mem_rd_valid) begin
        mem_rd_valid = 1;
        mem_rd_data  = '1;
      end
    end else if (stray_en && was_real && !mem_rd_valid) begin
      mem_rd_valid = 1;
      mem_rd_data  = '1;
    end
  end

  // Scoreboard: read addresses and results
  always @(negedge clk) begin
    if (chk_res_next) begin
      chk("result_after_done", 32'(result), 32'(res_hold));
      chk_res_next = 0;
    end
    if (mem_rd_en) begin
      chk("rd_expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
    if (done) begin
      chk("done_expected", 32'(exp_res.size() > 0), 32'd1);
      if (exp_res.size() > 0) begin
        res_hold     = exp_res.pop_front();
        chk_res_next = 1;
      end
    end
  end

  // Called at #1 after an edge (cycle 0); returns in cycle 1.
  task automatic issue(input logic [15:0] b, input logic [7:0] l);
    start = 1; base_addr = b; length = l;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(input string tag, input int cyc0, input int exp_cyc);
    int cyc;
    cyc = cyc0;
    while (!done && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1; start = 0; abort = 0; base_addr = '0; length = '0;
    mem_rd_valid = 0; mem_rd_data = '0;

    mem[16'h0010] = rep(16'h0001);
    mem[16'h0100] = rep(16'h0001);
    mem[16'h0101] = rep(16'h0002);
    mem[16'h0102] = rep(16'h0003);
    for (int i = 0; i < 16; i++) mem[16'h0200 + i] = rep(16'h0100);
    mem[16'hFFFF] = rep(16'h0005);
    mem[16'h0000] = rep(16'h0007);
    mem[16'h0300] = rep(16'h0011);
    mem[16'h0301] = rep(16'h0022);
    mem[16'h0380] = 256'h1234;
    mem[16'h0400] = rep(16'h0001);
    mem[16'h0401] = rep(16'h0777);
    mem[16'h0410] = rep(16'h0002);
    for (int i = 0; i < 4; i++) mem[16'h0600 + i] = rep(16'h0001);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_sum_bus_nz", 32'(sum_bus != '0), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 0;

    // Single word
    @(posedge clk); #1;
    exp_addr.push_back(16'h0010); exp_res.push_back(16'h0010);
    issue(16'h0010, 8'd1);
    chk("t1_busy_c1", 32'(busy), 32'd1);
    wait_done("t1", 1, 4);

    // Three words
    @(posedge clk); #1;
    exp_addr.push_back(16'h0100); exp_addr.push_back(16'h0101); exp_addr.push_back(16'h0102);
    exp_res.push_back(16'h0060);
    issue(16'h0100, 8'd3);
    wait_done("t2", 1, 10);

    // Accumulator wrap: 16 x 0x1000
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) exp_addr.push_back(16'h0200 + 16'(i));
    exp_res.push_back(16'h0000);
    issue(16'h0200, 8'd16);
    wait_done("t3", 1, 49);

    // Address wrap
    @(posedge clk); #1;
    exp_addr.push_back(16'hFFFF); exp_addr.push_back(16'h0000);
    exp_res.push_back(16'h00C0);
    issue(16'hFFFF, 8'd2);
    wait_done("t4", 1, 7);

    // length = 0 overwrites nonzero result
    @(posedge clk); #1;
    exp_res.push_back(16'h0000);
    issue(16'h0020, 8'd0);
    wait_done("t5", 1, 1);

    // Slow second word, stray valids, start while busy
    @(posedge clk); #1;
    lat_q.push_back(1); lat_q.push_back(4);
    stray_en = 1;
    exp_addr.push_back(16'h0300); exp_addr.push_back(16'h0301);
    exp_res.push_back(16'h0330);
    issue(16'h0300, 8'd2);
    @(posedge clk); #1;
    start = 1; base_addr = 16'h0500; length = 8'd5;
    @(posedge clk); #1;
    start = 0;
    wait_done("t6", 3, 10);
    stray_en = 0;

    // Set result to 0x1234
    @(posedge clk); #1;
    exp_addr.push_back(16'h0380); exp_res.push_back(16'h1234);
    issue(16'h0380, 8'd1);
    wait_done("t7", 1, 4);

    // Abort in WAIT of word 2, late return, immediate restart
    @(posedge clk); #1;
    lat_q.push_back(1); lat_q.push_back(2);
    exp_addr.push_back(16'h0400); exp_addr.push_back(16'h0401);
    issue(16'h0400, 8'd3);
    repeat (4) @(posedge clk);
    #1;
    chk("t8_busy_wait", 32'(busy), 32'd1);
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("t8_abort_idle", 32'(busy), 32'd0);
    chk("t8_abort_nodone", 32'(done), 32'd0);
    chk("t8_abort_result", 32'(result), 32'h1234);
    exp_addr.push_back(16'h0410); exp_res.push_back(16'h0020);
    issue(16'h0410, 8'd1);
    wait_done("t8", 1, 4);

    // Reset mid-run
    @(posedge clk); #1;
    exp_addr.push_back(16'h0600); exp_addr.push_back(16'h0601);
    issue(16'h0600, 8'd4);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("t9_rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("t9_rst_addr", 32'(mem_addr), 32'd0);
    chk("t9_rst_sum_bus_nz", 32'(sum_bus != '0), 32'd0);
    chk("t9_rst_result", 32'(result), 32'd0);
    chk("t9_rst_busy", 32'(busy), 32'd0);
    chk("t9_rst_done", 32'(done), 32'd0);
    rst = 0;
    @(posedge clk); #1;
    exp_addr.push_back(16'h0010); exp_res.push_back(16'h0010);
    issue(16'h0010, 8'd1);
    wait_done("t9", 1, 4);

    repeat (2) @(posedge clk);
    #1;
    chk("end_addr_q", 32'(exp_addr.size()), 32'd0);
    chk("end_res_q", 32'(exp_res.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
